// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: sign-magnitude shift-add multiply
// and restoring divide, one bit per cycle, with optional fast special cases.
module muldiv_seq #(
  parameter int WIDTH        = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             kill_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   res_q, res_d;

  logic             a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             b_zero, dz, ovf, special;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (op_i)
      3'b000, 3'b001,
      3'b100, 3'b110: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'b010: a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign a_neg   = a_sgn & a_i[WIDTH-1];
  assign b_neg   = b_sgn & b_i[WIDTH-1];
  assign abs_a   = a_neg ? -a_i : a_i;
  assign abs_b   = b_neg ? -b_i : b_i;
  assign b_zero  = (b_i == '0);
  assign dz      = op_i[2] & b_zero;
  assign ovf     = op_i[2] & ~op_i[0] & (a_i == MIN) & (b_i == ONES);
  assign special = dz | ovf;

  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH:0]     msum, dtmp;
  logic               dge;
  logic [WIDTH-1:0]   drem;
  logic [2*WIDTH-1:0] mul_nx, div_nx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, remv, sel;

  assign hi     = acc_q[2*WIDTH-1:WIDTH];
  assign lo     = acc_q[WIDTH-1:0];
  assign msum   = {1'b0, hi} + (lo[0] ? {1'b0, dvs_q} : '0);
  assign mul_nx = {msum, lo[WIDTH-1:1]};
  assign dtmp   = {hi, lo[WIDTH-1]};
  assign dge    = (dtmp >= {1'b0, dvs_q});
  // Difference always fits WIDTH bits when dge holds.
  assign drem   = dge ? (dtmp[WIDTH-1:0] - dvs_q) : dtmp[WIDTH-1:0];
  assign div_nx = {drem, lo[WIDTH-2:0], dge};

  assign prod = negq_q ? -acc_q : acc_q;
  assign quot = negq_q ? -lo : lo;
  assign remv = negr_q ? -hi : hi;

  always_comb begin
    sel = remv;
    unique case (op_q)
      3'b000:                 sel = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: sel = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         sel = quot;
      default:                sel = remv;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && !kill_i && !done_q) begin
          op_d    = op_i;
          negq_d  = (a_neg ^ b_neg) & ~dz;
          negr_d  = a_neg;
          dvs_d   = op_i[2] ? abs_b : abs_a;
          acc_d   = {{WIDTH{1'b0}}, op_i[2] ? abs_a : abs_b};
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          state_d = CALC;
          if (FAST_SPECIAL && special) begin
            state_d = FIX;
            if (dz) acc_d = {abs_a, ONES};
          end
        end
      end
      CALC: begin
        if (kill_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d = op_q[2] ? div_nx : mul_nx;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!kill_i) begin
          res_d  = sel;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = res_q;

endmodule
